// File: rtl/bythoven_pkg.sv
// Shared definitions for the song-SRAM writer: bus widths, default load address
// and the loader state encoding.
package bythoven_pkg;
    localparam int SRAM_AW = 18;
    localparam int SRAM_DW = 16;
    localparam logic [SRAM_AW-1:0] DEF_BASE_ADDR = '0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DAT_LO,
        ST_DAT_HI,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_CSUM,
        ST_FIN
    } ld_state_e;
endpackage

// File: rtl/sram_loader_if.sv
// Byte-stream input, SRAM write bus and load status of the song loader.
// master = the loader, slave = the surrounding top level / environment.
interface sram_loader_if;
    import bythoven_pkg::*;

    logic               START;
    logic [7:0]         IN_DATA;
    logic               IN_VALID;
    logic               IN_READY;
    logic               SRAM_WE;
    logic               SRAM_CE;
    logic               SRAM_OE;
    logic               SRAM_LB;
    logic               SRAM_UB;
    logic [SRAM_AW-1:0] SRAM_A;
    logic [SRAM_DW-1:0] SRAM_DQ_O;
    logic               BUS_REQ;
    logic               DONE;
    logic               ERR;
    logic [15:0]        WORDS;

    modport master (
        input  START, IN_DATA, IN_VALID,
        output IN_READY, SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB,
               SRAM_A, SRAM_DQ_O, BUS_REQ, DONE, ERR, WORDS
    );

    modport slave (
        output START, IN_DATA, IN_VALID,
        input  IN_READY, SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB,
               SRAM_A, SRAM_DQ_O, BUS_REQ, DONE, ERR, WORDS
    );
endinterface

// File: rtl/sram_write_strobe.sv
// One SRAM write cycle: a setup cycle with WE high, then we_cycles cycles of WE low.
// done marks the last low cycle so the caller can follow with its hold cycle.
module sram_write_strobe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       go,
    input  logic [3:0] we_cycles,
    output logic       we_n,
    output logic       done
);
    typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_STROBE} ph_e;

    ph_e        ph_q, ph_d;
    logic [3:0] cnt_q, cnt_d;
    logic       we_n_q, we_n_d;

    always_comb begin
        ph_d   = ph_q;
        cnt_d  = cnt_q;
        we_n_d = 1'b1;
        case (ph_q)
            PH_IDLE:  if (go) ph_d = PH_SETUP;
            PH_SETUP: begin
                ph_d   = PH_STROBE;
                cnt_d  = 4'd1;
                we_n_d = 1'b0;
            end
            PH_STROBE: begin
                if (cnt_q >= we_cycles) begin
                    ph_d = PH_IDLE;
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    we_n_d = 1'b0;
                end
            end
            default: ph_d = PH_IDLE;
        endcase
    end

    // we_n_q resets asynchronously so an aborted write releases WE at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q   <= PH_IDLE;
            cnt_q  <= 4'd0;
            we_n_q <= 1'b1;
        end else begin
            ph_q   <= ph_d;
            cnt_q  <= cnt_d;
            we_n_q <= we_n_d;
        end
    end

    assign we_n = we_n_q;
    assign done = (ph_q == PH_STROBE) && (cnt_q >= we_cycles);
endmodule

// File: rtl/sram_loader.sv
// Frames the incoming byte stream into little-endian words and writes them to SRAM.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module sram_loader
    import bythoven_pkg::*;
#(
    parameter logic [SRAM_AW-1:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned        WE_CYCLES = 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    sram_loader_if.master bus
);
`ifdef LOADER_CHECKSUM_EN
    localparam bit        CSUM_EN = 1'b1;
    localparam ld_state_e END_ST  = ST_CSUM;
`else
    localparam bit        CSUM_EN = 1'b0;
    localparam ld_state_e END_ST  = ST_FIN;
`endif

    ld_state_e          state_q, state_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [SRAM_DW-1:0] data_q, data_d;
    logic [15:0]        len_q, len_d;
    logic [15:0]        words_q, words_d;
    logic [7:0]         csum_q, csum_d;
    logic               bus_req_q, bus_req_d;
    logic               in_ready_q, in_ready_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic        accept, go, strobe_done, we_n;
    logic [15:0] words_inc;

    assign accept    = bus.IN_VALID && in_ready_q;
    assign words_inc = words_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        len_d     = len_q;
        words_d   = words_q;
        csum_d    = csum_q;
        bus_req_d = bus_req_q;
        done_d    = done_q;
        err_d     = err_q;
        go        = 1'b0;
        if (accept && state_q != ST_CSUM) csum_d = csum_q ^ bus.IN_DATA;
        case (state_q)
            ST_IDLE: if (bus.START) begin
                done_d    = 1'b0;
                err_d     = 1'b0;
                words_d   = '0;
                csum_d    = '0;
                addr_d    = BASE_ADDR;
                bus_req_d = 1'b1;
                state_d   = ST_LEN_LO;
            end
            ST_LEN_LO: if (accept) begin
                len_d[7:0] = bus.IN_DATA;
                state_d    = ST_LEN_HI;
            end
            ST_LEN_HI: if (accept) begin
                len_d[15:8] = bus.IN_DATA;
                state_d     = ({bus.IN_DATA, len_q[7:0]} == 16'd0) ? END_ST : ST_DAT_LO;
            end
            ST_DAT_LO: if (accept) begin
                data_d[7:0] = bus.IN_DATA;
                state_d     = ST_DAT_HI;
            end
            ST_DAT_HI: if (accept) begin
                data_d[15:8] = bus.IN_DATA;
                go           = 1'b1;
                state_d      = ST_SETUP;
            end
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: if (strobe_done) state_d = ST_HOLD;
            ST_HOLD: begin
                // address wraps naturally at the 18-bit boundary
                addr_d = addr_q + 1'b1;
                if (words_q != len_q && words_q != 16'hFFFF) words_d = words_inc;
                state_d = (words_inc == len_q) ? END_ST : ST_DAT_LO;
            end
            ST_CSUM: if (accept) begin
                if (CSUM_EN && bus.IN_DATA != csum_q) err_d = 1'b1;
                state_d = ST_FIN;
            end
            ST_FIN: begin
                done_d    = 1'b1;
                bus_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d = (state_d == ST_LEN_LO) || (state_d == ST_LEN_HI) ||
                     (state_d == ST_DAT_LO) || (state_d == ST_DAT_HI) ||
                     (state_d == ST_CSUM);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            addr_q     <= BASE_ADDR;
            data_q     <= '0;
            len_q      <= '0;
            words_q    <= '0;
            csum_q     <= '0;
            bus_req_q  <= 1'b0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            len_q      <= len_d;
            words_q    <= words_d;
            csum_q     <= csum_d;
            bus_req_q  <= bus_req_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    sram_write_strobe u_strobe (
        .clk       (CLK),
        .rst_n     (RST_N),
        .go        (go),
        .we_cycles (4'(WE_CYCLES)),
        .we_n      (we_n),
        .done      (strobe_done)
    );

    assign bus.IN_READY  = in_ready_q;
    assign bus.SRAM_WE   = we_n;
    assign bus.SRAM_CE   = ~bus_req_q;
    assign bus.SRAM_LB   = ~bus_req_q;
    assign bus.SRAM_UB   = ~bus_req_q;
    assign bus.SRAM_OE   = 1'b1;
    assign bus.SRAM_A    = addr_q;
    assign bus.SRAM_DQ_O = data_q;
    assign bus.BUS_REQ   = bus_req_q;
    assign bus.DONE      = done_q;
    assign bus.ERR       = CSUM_EN ? err_q : 1'b0;
    assign bus.WORDS     = words_q;
endmodule
